// File: rtl/b_resp_router_if.sv
// b_resp_router_if: AW-grant, B-channel and status bundle for the write-response router
interface b_resp_router_if #(
  parameter int NUM_MASTERS = 16,
  parameter int FIFO_DEPTH  = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  logic [NUM_MASTERS-1:0]   aw_grant_id_i;
  logic                     aw_hs_i;
  logic                     aw_allow_o;
  logic [1:0]               s_axi_bresp_i;
  logic                     s_axi_bvalid_i;
  logic                     s_axi_bready_o;
  logic [2*NUM_MASTERS-1:0] m_axi_bresp_o;
  logic [NUM_MASTERS-1:0]   m_axi_bvalid_o;
  logic [NUM_MASTERS-1:0]   m_axi_bready_i;
  logic [CNT_W-1:0]         outstanding_o;
  logic [1:0]               err_o;
  modport slave (
    input  aw_grant_id_i, aw_hs_i, s_axi_bresp_i, s_axi_bvalid_i, m_axi_bready_i,
    output aw_allow_o, s_axi_bready_o, m_axi_bresp_o, m_axi_bvalid_o, outstanding_o, err_o
  );
  modport master (
    output aw_grant_id_i, aw_hs_i, s_axi_bresp_i, s_axi_bvalid_i, m_axi_bready_i,
    input  aw_allow_o, s_axi_bready_o, m_axi_bresp_o, m_axi_bvalid_o, outstanding_o, err_o
  );
endinterface

// File: rtl/b_resp_router.sv
// b_resp_router: in-order B-response return path; optional master-side register slice via B_RESP_REGSLICE_EN
module b_resp_router #(
  parameter int NUM_MASTERS = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input logic           axi_aclk_i,
  input logic           axi_areset_i,
  b_resp_router_if.slave bus
);
  localparam int IDX_W = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  logic [IDX_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       err;
  logic [IDX_W-1:0] enc_idx, head;
  logic             empty, full, any_grant, push, pop;
  assign empty          = count == '0;
  assign full           = count == CNT_W'(FIFO_DEPTH);
  assign any_grant      = |bus.aw_grant_id_i;
  assign push           = bus.aw_hs_i & any_grant & !full;
  assign head           = mem[rptr];
  assign bus.aw_allow_o    = !full;
  assign bus.outstanding_o = count;
  assign bus.err_o         = err;
  // one-hot to binary; scanning downward lets the lowest set bit win on multi-hot grants
  always_comb begin
    enc_idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (bus.aw_grant_id_i[i]) enc_idx = IDX_W'(i);
  end
`ifdef B_RESP_REGSLICE_EN
  logic             slice_valid;
  logic [IDX_W-1:0] slice_idx;
  logic [1:0]       slice_resp;
  assign bus.s_axi_bready_o = !empty & (!slice_valid | bus.m_axi_bready_i[slice_idx]);
  assign pop                = bus.s_axi_bvalid_i & bus.s_axi_bready_o;
  assign bus.m_axi_bvalid_o = NUM_MASTERS'(slice_valid) << slice_idx;
  assign bus.m_axi_bresp_o  = (2*NUM_MASTERS)'(slice_valid ? slice_resp : 2'b00) << {slice_idx, 1'b0};
  // slice reloads on every slave handshake and drains when its master accepts
  always_ff @(posedge axi_aclk_i or posedge axi_areset_i)
    if (axi_areset_i) begin
      slice_valid <= 1'b0;
      slice_idx   <= '0;
      slice_resp  <= 2'b00;
    end else if (pop) begin
      slice_valid <= 1'b1;
      slice_idx   <= head;
      slice_resp  <= bus.s_axi_bresp_i;
    end else if (slice_valid & bus.m_axi_bready_i[slice_idx]) begin
      slice_valid <= 1'b0;
    end
`else
  logic route;
  assign route              = !empty & bus.s_axi_bvalid_i;
  assign bus.s_axi_bready_o = !empty & bus.m_axi_bready_i[head];
  assign pop                = bus.s_axi_bvalid_i & bus.s_axi_bready_o;
  assign bus.m_axi_bvalid_o = NUM_MASTERS'(route) << head;
  assign bus.m_axi_bresp_o  = (2*NUM_MASTERS)'(route ? bus.s_axi_bresp_i : 2'b00) << {head, 1'b0};
`endif
  // queue pointers, occupancy and sticky error flags
  always_ff @(posedge axi_aclk_i or posedge axi_areset_i)
    if (axi_areset_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      err   <= 2'b00;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      err   <= err | {bus.aw_hs_i & (full | !any_grant), bus.s_axi_bvalid_i & empty};
    end
  // ID storage needs no reset: the pointers alone define which entries are live
  always_ff @(posedge axi_aclk_i)
    if (push) mem[wptr] <= enc_idx;
endmodule

// File: tb/tb_b_resp_router.sv
// tb_b_resp_router: directed scoreboard bench for the combinational (default) build of b_resp_router
module tb_b_resp_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int sb[$];
  int exp_cnt = 0;
  int h;
  always #5 clk = ~clk;
  b_resp_router_if #(.NUM_MASTERS(16), .FIFO_DEPTH(4)) bus ();
  b_resp_router #(.NUM_MASTERS(16), .FIFO_DEPTH(4)) dut (
    .axi_aclk_i  (clk),
    .axi_areset_i(rst),
    .bus         (bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int low_idx(input logic [15:0] g);
    for (int i = 0; i < 16; i++) if (g[i]) return i;
    return -1;
  endfunction
  task automatic push(input logic [15:0] g);
    bus.aw_grant_id_i = g;
    bus.aw_hs_i = 1'b1;
    if (g != 16'h0 && exp_cnt < 4) begin
      sb.push_back(low_idx(g));
      exp_cnt++;
    end
    tick();
    bus.aw_hs_i = 1'b0;
    bus.aw_grant_id_i = 16'h0;
  endtask
  task automatic resp(input string tag, input logic [1:0] r);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    h = sb[0];
    bus.s_axi_bvalid_i = 1'b1;
    bus.s_axi_bresp_i = r;
    bus.m_axi_bready_i = 16'(1) << h;
    #3;
    chk({tag, "_bvalid"}, 32'(bus.m_axi_bvalid_o), 32'(1) << h);
    chk({tag, "_bresp"}, 32'(bus.m_axi_bresp_o), 32'(r) << (2 * h));
    chk({tag, "_bready"}, 32'(bus.s_axi_bready_o), 32'd1);
    tick();
    void'(sb.pop_front());
    exp_cnt--;
    bus.s_axi_bvalid_i = 1'b0;
    bus.m_axi_bready_i = 16'h0;
    chk({tag, "_cnt"}, 32'(bus.outstanding_o), 32'(exp_cnt));
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_allow"}, 32'(bus.aw_allow_o), 32'd1);
    chk({tag, "_cnt"}, 32'(bus.outstanding_o), 32'd0);
    chk({tag, "_bready"}, 32'(bus.s_axi_bready_o), 32'd0);
    chk({tag, "_bvalid"}, 32'(bus.m_axi_bvalid_o), 32'd0);
    chk({tag, "_bresp"}, 32'(bus.m_axi_bresp_o), 32'd0);
    chk({tag, "_err"}, 32'(bus.err_o), 32'd0);
  endtask
  initial begin
    bus.aw_grant_id_i = 16'h0;
    bus.aw_hs_i = 1'b0;
    bus.s_axi_bresp_i = 2'b00;
    bus.s_axi_bvalid_i = 1'b0;
    bus.m_axi_bready_i = 16'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_reset("idle");
    push(16'h0020);
    chk("single_cnt", 32'(bus.outstanding_o), 32'd1);
    resp("single", 2'b00);
    push(16'h0001);
    push(16'h0008);
    push(16'h0080);
    push(16'h0400);
    chk("full_allow", 32'(bus.aw_allow_o), 32'd0);
    chk("full_cnt", 32'(bus.outstanding_o), 32'd4);
    chk("full_err_clean", 32'(bus.err_o), 32'd0);
    push(16'h0002);
    chk("drop_err", 32'(bus.err_o), 32'b10);
    chk("drop_cnt", 32'(bus.outstanding_o), 32'd4);
    resp("r0", 2'b00);
    chk("after_pop_allow", 32'(bus.aw_allow_o), 32'd1);
    h = sb[0];
    bus.aw_grant_id_i = 16'h0004;
    bus.aw_hs_i = 1'b1;
    bus.s_axi_bvalid_i = 1'b1;
    bus.s_axi_bresp_i = 2'b01;
    bus.m_axi_bready_i = 16'(1) << h;
    #3;
    chk("pp_bvalid", 32'(bus.m_axi_bvalid_o), 32'h0008);
    chk("pp_bresp", 32'(bus.m_axi_bresp_o), 32'h0000_0040);
    tick();
    void'(sb.pop_front());
    sb.push_back(2);
    bus.aw_hs_i = 1'b0;
    bus.aw_grant_id_i = 16'h0;
    bus.s_axi_bvalid_i = 1'b0;
    bus.m_axi_bready_i = 16'h0;
    chk("pp_cnt", 32'(bus.outstanding_o), 32'd3);
    resp("r2", 2'b10);
    resp("r3", 2'b11);
    resp("r_m2", 2'b01);
    chk("drain_bready", 32'(bus.s_axi_bready_o), 32'd0);
    bus.s_axi_bvalid_i = 1'b1;
    bus.s_axi_bresp_i = 2'b01;
    bus.m_axi_bready_i = 16'hFFFF;
    #3;
    chk("empty_bready", 32'(bus.s_axi_bready_o), 32'd0);
    chk("empty_bvalid", 32'(bus.m_axi_bvalid_o), 32'd0);
    tick();
    chk("empty_err", 32'(bus.err_o), 32'b11);
    chk("empty_cnt", 32'(bus.outstanding_o), 32'd0);
    bus.aw_grant_id_i = 16'h0100;
    bus.aw_hs_i = 1'b1;
    #3;
    chk("samecyc_bvalid", 32'(bus.m_axi_bvalid_o), 32'd0);
    tick();
    bus.aw_hs_i = 1'b0;
    bus.aw_grant_id_i = 16'h0;
    #2;
    chk("m8_bvalid", 32'(bus.m_axi_bvalid_o), 32'h0100);
    chk("m8_bresp", 32'(bus.m_axi_bresp_o), 32'h0001_0000);
    chk("m8_bready", 32'(bus.s_axi_bready_o), 32'd1);
    tick();
    bus.s_axi_bvalid_i = 1'b0;
    bus.m_axi_bready_i = 16'h0;
    chk("m8_cnt", 32'(bus.outstanding_o), 32'd0);
    push(16'h0004);
    bus.s_axi_bvalid_i = 1'b1;
    bus.s_axi_bresp_i = 2'b11;
    bus.m_axi_bready_i = 16'hFFFB;
    for (int c = 0; c < 5; c++) begin
      #3;
      chk($sformatf("stall%0d_bready", c), 32'(bus.s_axi_bready_o), 32'd0);
      chk($sformatf("stall%0d_bvalid", c), 32'(bus.m_axi_bvalid_o), 32'h0004);
      chk($sformatf("stall%0d_bresp", c), 32'(bus.m_axi_bresp_o), 32'h0000_0030);
      tick();
    end
    chk("stall_cnt", 32'(bus.outstanding_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    sb.delete();
    exp_cnt = 0;
    bus.s_axi_bvalid_i = 1'b0;
    bus.m_axi_bready_i = 16'h0;
    tick();
    rst = 1'b0;
    tick();
    push(16'h0000);
    chk("zerohot_err", 32'(bus.err_o), 32'b10);
    chk("zerohot_cnt", 32'(bus.outstanding_o), 32'd0);
    push(16'h0A00);
    chk("multihot_cnt", 32'(bus.outstanding_o), 32'd1);
    resp("multihot", 2'b10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
